// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : MIPS decode/issue stage in front of the ALU. It builds the
//             operands, loads the ID/EX register and stalls on RAW hazards
//             using a 2-entry scoreboard. Define FORWARD_EN to forward
//             non-load results from MEM.
//  Revision : 1.0
// ============================================================================
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    input  logic              flush,
    input  logic              ex_stall,
    output logic [RA_W-1:0]   rf_raddr1,
    output logic [RA_W-1:0]   rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic [DATA_W-1:0] mem_result,
    output logic              ex_valid,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_ar_op,
    output logic [4:0]        ex_shamt,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_store_dat,
    output logic [RA_W-1:0]   ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_MUL   = 6'b011100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_LBU   = 6'b100100;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_SB    = 6'b101000;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    logic [5:0]        w_opc;
    logic [5:0]        w_funct;
    logic [15:0]       w_imm;
    logic [RA_W-1:0]   w_rs;
    logic [RA_W-1:0]   w_rt;
    logic [RA_W-1:0]   w_rdf;
    logic              w_is_rtype;
    logic              w_is_mul;
    logic              w_is_lui;
    logic              w_is_alui;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_uses_rs;
    logic              w_uses_rt;
    logic              w_has_dest;
    logic [RA_W-1:0]   w_dest;
    logic              w_reg_write;
    logic              w_sbex_v;
    logic              w_rs_ex;
    logic              w_rt_ex;
    logic              w_rs_mem;
    logic              w_rt_mem;
    logic              w_rs_fwd;
    logic              w_rt_fwd;
    logic              w_rs_stall;
    logic              w_rt_stall;
    logic              w_hazard;
    logic              w_xfer;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_op2;

    logic              r_ex_valid;
    logic [5:0]        r_ex_opcode;
    logic [5:0]        r_ex_ar_op;
    logic [4:0]        r_ex_shamt;
    logic [DATA_W-1:0] r_ex_op1;
    logic [DATA_W-1:0] r_ex_op2;
    logic [DATA_W-1:0] r_ex_store_dat;
    logic [RA_W-1:0]   r_ex_rd;
    logic              r_ex_reg_write;
    logic              r_ex_mem_read;
    logic              r_ex_mem_write;
    logic              r_sbmem_v;
    logic [RA_W-1:0]   r_sbmem_rd;
    logic              r_sbmem_ld;

    assign w_opc   = if_instr[31:26];
    assign w_funct = if_instr[5:0];
    assign w_imm   = if_instr[15:0];
    assign w_rs    = RA_W'(if_instr[25:21]);
    assign w_rt    = RA_W'(if_instr[20:16]);
    assign w_rdf   = RA_W'(if_instr[15:11]);

    assign rf_raddr1 = w_rs;
    assign rf_raddr2 = w_rt;

    assign w_is_rtype = (w_opc == c_OP_RTYPE);
    assign w_is_mul   = (w_opc == c_OP_MUL);
    assign w_is_lui   = (w_opc == c_OP_LUI);
    assign w_is_alui  = (w_opc == c_OP_ADDI) || (w_opc == c_OP_ADDIU) || (w_opc == c_OP_SLTI);
    assign w_is_load  = (w_opc == c_OP_LW) || (w_opc == c_OP_LBU);
    assign w_is_store = (w_opc == c_OP_SW) || (w_opc == c_OP_SB);
    assign w_uses_rs  = !w_is_lui;
    assign w_uses_rt  = w_is_rtype || w_is_mul || w_is_store;

    always_comb begin
        w_has_dest = 1'b0;
        w_dest     = '0;
        if ((w_is_rtype && (w_funct != c_FN_JR)) || w_is_mul) begin
            w_has_dest = 1'b1;
            w_dest     = w_rdf;
        end else if (w_is_alui || w_is_lui || w_is_load) begin
            w_has_dest = 1'b1;
            w_dest     = w_rt;
        end
    end

    // $0 is hardwired, so an instruction targeting it never writes.
    assign w_reg_write = w_has_dest && (w_dest != '0);

    assign w_sbex_v = r_ex_valid && r_ex_reg_write;
    assign w_rs_ex  = (w_rs != '0) && w_sbex_v  && (w_rs == r_ex_rd);
    assign w_rt_ex  = (w_rt != '0) && w_sbex_v  && (w_rt == r_ex_rd);
    assign w_rs_mem = (w_rs != '0) && r_sbmem_v && (w_rs == r_sbmem_rd);
    assign w_rt_mem = (w_rt != '0) && r_sbmem_v && (w_rt == r_sbmem_rd);

`ifdef FORWARD_EN
    // The youngest producer (EX) wins; a load in MEM has no data yet.
    assign w_rs_fwd   = w_rs_mem && !r_sbmem_ld && !w_rs_ex;
    assign w_rt_fwd   = w_rt_mem && !r_sbmem_ld && !w_rt_ex;
    assign w_rs_stall = w_rs_ex || (w_rs_mem && r_sbmem_ld);
    assign w_rt_stall = w_rt_ex || (w_rt_mem && r_sbmem_ld);
`else
    logic w_unused;
    assign w_unused   = ^{mem_result, r_sbmem_ld};
    assign w_rs_fwd   = 1'b0;
    assign w_rt_fwd   = 1'b0;
    assign w_rs_stall = w_rs_ex || w_rs_mem;
    assign w_rt_stall = w_rt_ex || w_rt_mem;
`endif

    assign w_hazard = (w_uses_rs && w_rs_stall) || (w_uses_rt && w_rt_stall);
    assign if_ready = !reset && !ex_stall && !flush && !w_hazard;
    assign w_xfer   = if_valid && if_ready;

    assign w_rs_val = w_rs_fwd ? mem_result : rf_rdata1;
    assign w_rt_val = w_rt_fwd ? mem_result : rf_rdata2;

    always_comb begin
        if (w_is_rtype || w_is_mul) begin
            w_op2 = w_rt_val;
        end else if (w_is_lui) begin
            w_op2 = {{(DATA_W-16){1'b0}}, w_imm};
        end else begin
            w_op2 = {{(DATA_W-16){w_imm[15]}}, w_imm};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid     <= 1'b0;
            r_ex_opcode    <= '0;
            r_ex_ar_op     <= '0;
            r_ex_shamt     <= '0;
            r_ex_op1       <= '0;
            r_ex_op2       <= '0;
            r_ex_store_dat <= '0;
            r_ex_rd        <= '0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_sbmem_v      <= 1'b0;
            r_sbmem_rd     <= '0;
            r_sbmem_ld     <= 1'b0;
        end else if (!ex_stall) begin
            r_sbmem_v  <= w_sbex_v;
            r_sbmem_rd <= r_ex_rd;
            r_sbmem_ld <= r_ex_mem_read;
            if (w_xfer) begin
                r_ex_valid     <= 1'b1;
                r_ex_opcode    <= w_opc;
                r_ex_ar_op     <= w_funct;
                r_ex_shamt     <= if_instr[10:6];
                r_ex_op1       <= w_rs_val;
                r_ex_op2       <= w_op2;
                r_ex_store_dat <= w_rt_val;
                r_ex_rd        <= w_reg_write ? w_dest : '0;
                r_ex_reg_write <= w_reg_write;
                r_ex_mem_read  <= w_is_load;
                r_ex_mem_write <= w_is_store;
            end else begin
                r_ex_valid     <= 1'b0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
                r_ex_mem_write <= 1'b0;
            end
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_opcode    = r_ex_opcode;
    assign ex_ar_op     = r_ex_ar_op;
    assign ex_shamt     = r_ex_shamt;
    assign ex_op1       = r_ex_op1;
    assign ex_op2       = r_ex_op2;
    assign ex_store_dat = r_ex_store_dat;
    assign ex_rd        = r_ex_rd;
    assign ex_reg_write = r_ex_reg_write;
    assign ex_mem_read  = r_ex_mem_read;
    assign ex_mem_write = r_ex_mem_write;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Directed plus randomized bench for alu_issue_stage with an
//             in-flight-instruction reference model.
//  Revision : 1.0
// ============================================================================
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_instr = '0;
    logic        flush = 1'b0;
    logic        ex_stall = 1'b0;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [31:0] mem_result = '0;
    logic        ex_valid;
    logic [5:0]  ex_opcode, ex_ar_op;
    logic [4:0]  ex_shamt;
    logic [31:0] ex_op1, ex_op2, ex_store_dat;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    logic [31:0] rf [32];
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(32), .RA_W(5)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .flush(flush), .ex_stall(ex_stall),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .mem_result(mem_result),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_ar_op(ex_ar_op),
        .ex_shamt(ex_shamt), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_store_dat(ex_store_dat), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what sits in EX, and the producer currently in MEM.
    typedef struct {
        logic        v;
        logic [5:0]  opc;
        logic [5:0]  arop;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        uses_rs;
        logic        zero;
    } ex_t;

    typedef struct {
        logic       wr;
        logic [4:0] rd;
        logic       ld;
    } prod_t;

    ex_t   m_ex, m_ex_nxt;
    prod_t m_mem, m_mem_nxt;
    bit    model_on = 1'b0;

    // 0: register file is current, 1: take mem_result, 2: must wait
    function automatic int src_state(input logic [4:0] r);
        if (r == 5'd0) return 0;
        if (m_ex.v && m_ex.rw && m_ex.rd == r) return 2;
        if (m_mem.wr && m_mem.rd == r) begin
`ifdef FORWARD_EN
            return m_mem.ld ? 2 : 1;
`else
            return 2;
`endif
        end
        return 0;
    endfunction

    function automatic logic [31:0] reg_value(input logic [4:0] r);
        return (src_state(r) == 1) ? mem_result : rf[r];
    endfunction

    function automatic bit is_store(input logic [5:0] o);
        return o == 6'b101011 || o == 6'b101000;
    endfunction

    function automatic bit hazard(input logic [31:0] ins);
        logic [5:0] o;
        bit urs, urt;
        o   = ins[31:26];
        urs = (o != 6'b001111);
        urt = (o == 6'b000000) || (o == 6'b011100) || is_store(o);
        return (urs && src_state(ins[25:21]) == 2) || (urt && src_state(ins[20:16]) == 2);
    endfunction

    function automatic ex_t decode(input logic [31:0] ins);
        ex_t e;
        logic [5:0]  o;
        logic [15:0] imm;
        int dst;
        o       = ins[31:26];
        imm     = ins[15:0];
        e.v     = 1'b1;
        e.zero  = 1'b0;
        e.opc   = o;
        e.arop  = ins[5:0];
        e.shamt = ins[10:6];
        e.op1   = reg_value(ins[25:21]);
        e.sd    = reg_value(ins[20:16]);
        e.uses_rs = (o != 6'b001111);
        e.mr    = (o == 6'b100011) || (o == 6'b100100);
        e.mw    = is_store(o);
        if (o == 6'b000000 || o == 6'b011100) e.op2 = reg_value(ins[20:16]);
        else if (o == 6'b001111)              e.op2 = {16'h0000, imm};
        else                                  e.op2 = {{16{imm[15]}}, imm};
        dst = -1;
        case (o)
            6'b000000: if (ins[5:0] != 6'b001000) dst = int'(ins[15:11]);
            6'b011100: dst = int'(ins[15:11]);
            6'b001000, 6'b001001, 6'b001010, 6'b001111,
            6'b100011, 6'b100100: dst = int'(ins[20:16]);
            default: dst = -1;
        endcase
        e.rw = (dst > 0);
        e.rd = e.rw ? 5'(dst) : 5'd0;
        return e;
    endfunction

    // Compare process: outputs checked every cycle, model advanced here.
    always @(negedge clk) begin
        if (model_on) begin
            bit exp_ready;
            exp_ready = !reset && !ex_stall && !flush && !hazard(if_instr);
            chk("if_ready", if_ready, exp_ready);
            chk("rf_raddr1", rf_raddr1, if_instr[25:21]);
            chk("rf_raddr2", rf_raddr2, if_instr[20:16]);
            chk("ex_valid", ex_valid, m_ex.v);
            chk("ex_reg_write", ex_reg_write, m_ex.rw);
            chk("ex_mem_read", ex_mem_read, m_ex.mr);
            chk("ex_mem_write", ex_mem_write, m_ex.mw);
            if (m_ex.v || m_ex.zero) begin
                chk("ex_opcode", ex_opcode, m_ex.opc);
                chk("ex_ar_op", ex_ar_op, m_ex.arop);
                chk("ex_shamt", ex_shamt, m_ex.shamt);
                chk("ex_op2", ex_op2, m_ex.op2);
                if (m_ex.rw || m_ex.zero)      chk("ex_rd", ex_rd, m_ex.rd);
                if (m_ex.uses_rs || m_ex.zero) chk("ex_op1", ex_op1, m_ex.op1);
                if (m_ex.mw || m_ex.zero)      chk("ex_store_dat", ex_store_dat, m_ex.sd);
            end
            if (reset) begin
                m_ex_nxt      = '{default: '0};
                m_ex_nxt.zero = 1'b1;
                m_mem_nxt     = '{default: '0};
            end else if (ex_stall) begin
                m_ex_nxt  = m_ex;
                m_mem_nxt = m_mem;
            end else begin
                m_mem_nxt = '{wr: m_ex.v && m_ex.rw, rd: m_ex.rd, ld: m_ex.mr};
                if (if_valid && exp_ready) begin
                    m_ex_nxt = decode(if_instr);
                end else begin
                    m_ex_nxt      = m_ex;
                    m_ex_nxt.v    = 1'b0;
                    m_ex_nxt.rw   = 1'b0;
                    m_ex_nxt.mr   = 1'b0;
                    m_ex_nxt.mw   = 1'b0;
                    m_ex_nxt.zero = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (model_on) begin
            m_ex  = m_ex_nxt;
            m_mem = m_mem_nxt;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] ins, output int stalls);
        bit ok;
        ok       = 1'b0;
        stalls   = 0;
        if_valid = 1'b1;
        if_instr = ins;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        chk("send_accept_timeout", ok, 1'b1);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        if_instr = '0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [5:0]  o, fn;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [5:0]  rfun [8];
        logic [5:0]  alu_i [3];
        rfun  = '{6'b100001, 6'b100011, 6'b100100, 6'b100101,
                  6'b000000, 6'b000010, 6'b001000, 6'b101010};
        alu_i = '{6'b001000, 6'b001001, 6'b001010};
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        sh  = 5'($urandom);
        imm = 16'($urandom);
        fn  = 6'($urandom);
        case ($urandom_range(0, 9))
            0, 1: begin
                fn = rfun[$urandom_range(0, 7)];
                return {6'b000000, rs, rt, rd, sh, fn};
            end
            2: return {6'b011100, rs, rt, rd, sh, 6'b000010};
            3: return {alu_i[$urandom_range(0, 2)], rs, rt, imm};
            4: return {6'b001111, rs, rt, imm};
            5: return {($urandom_range(0, 1) == 0) ? 6'b100011 : 6'b100100, rs, rt, imm};
            6: return {($urandom_range(0, 1) == 0) ? 6'b101011 : 6'b101000, rs, rt, imm};
            7: begin
                o = ($urandom_range(0, 1) == 0) ? 6'b000100 : 6'b001100;
                return {o, rs, rt, imm};
            end
            8: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int st, st2;
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
        mem_result = 32'hCAFE_0001;
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_ex       = '{default: '0};
        m_ex.zero  = 1'b1;
        m_ex_nxt   = m_ex;
        m_mem      = '{default: '0};
        m_mem_nxt  = m_mem;
        model_on   = 1'b1;
        @(negedge clk);
        chk("reset_ex_valid", ex_valid, 1'b0);
        chk("reset_ex_op1", ex_op1, 32'h0);
        chk("reset_if_ready", if_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // ADDIU $2,$0,-1
        send(32'h2402_FFFF, st);
        @(negedge clk);
        chk("addiu_opcode", ex_opcode, 6'b001001);
        chk("addiu_op2", ex_op2, 32'hFFFF_FFFF);
        chk("addiu_rd", ex_rd, 5'd2);
        chk("addiu_reg_write", ex_reg_write, 1'b1);
        idle(3);

        // LUI $3,0x1234 then ADDU $4,$2,$3 back to back
        send(32'h3C03_1234, st);
        if_valid = 1'b1;
        if_instr = 32'h0043_2021;
        @(negedge clk);
        chk("lui_op2", ex_op2, 32'h0000_1234);
        chk("raw_first_cycle_ready", if_ready, 1'b0);
        send(32'h0043_2021, st2);
`ifdef FORWARD_EN
        chk("lui_addu_stall_cycles", st2 + 1, 1);
`else
        chk("lui_addu_stall_cycles", st2 + 1, 2);
`endif
        @(negedge clk);
        chk("addu_op1", ex_op1, rf[2]);
`ifdef FORWARD_EN
        chk("addu_op2_fwd", ex_op2, 32'hCAFE_0001);
`else
        chk("addu_op2_rf", ex_op2, rf[3]);
`endif
        idle(3);

        // LW $5,0($1) then ADDU $6,$5,$5
        send(32'h8C25_0000, st);
        send(32'h00A5_3021, st);
        chk("load_use_stall_ge2", (st >= 2), 1'b1);
        idle(3);

        // SW $5,4($1)
        send(32'hAC25_0004, st);
        @(negedge clk);
        chk("sw_mem_write", ex_mem_write, 1'b1);
        chk("sw_reg_write", ex_reg_write, 1'b0);
        chk("sw_op2", ex_op2, 32'h0000_0004);
        chk("sw_store_dat", ex_store_dat, rf[5]);
        idle(3);

        // ex_stall for 3 cycles with an instruction waiting
        send(32'h00A5_3021, st);
        ex_stall = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h0043_2021;
        repeat (3) begin
            @(negedge clk);
            chk("stall_if_ready", if_ready, 1'b0);
            chk("stall_hold_op1", ex_op1, rf[5]);
            @(posedge clk);
            #1;
        end
        ex_stall = 1'b0;
        send(32'h0043_2021, st);
        idle(3);

        // flush drops the presented instruction
        flush    = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h2402_FFFF;
        @(negedge clk);
        chk("flush_if_ready", if_ready, 1'b0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        if_valid = 1'b0;
        @(negedge clk);
        chk("flush_ex_valid", ex_valid, 1'b0);
        idle(2);

        // reset during a stall
        send(32'h3C03_1234, st);
        ex_stall = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h0043_2021;
        idle(1);
        reset = 1'b1;
        idle(1);
        reset    = 1'b0;
        ex_stall = 1'b0;
        if_valid = 1'b0;
        @(negedge clk);
        chk("rst_stall_ex_valid", ex_valid, 1'b0);
        chk("rst_stall_ex_opcode", ex_opcode, 6'd0);
        chk("rst_stall_ex_op2", ex_op2, 32'h0);
        idle(1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 199) == 0);
            ex_stall   = ($urandom_range(0, 9) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            if_valid   = ($urandom_range(0, 9) < 7);
            if_instr   = gen_instr();
            mem_result = $urandom;
            @(posedge clk);
            #1;
        end
        reset    = 1'b0;
        ex_stall = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_instr = '0;
        idle(3);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
